// File: rtl/shift_serializer.sv
// Parallel-to-serial framer: START, LSB-first data, optional even parity, STOP, with a one-word holding buffer.
// Optional parity bit is built only when SHIFT_SER_PARITY_EN is defined.
module shift_serializer #(
    parameter int WIDTH_OUT_DATA = 16,
    parameter int BIT_TICKS      = 4
) (
    input  logic                    CLK_shift,
    input  logic                    RST_shift,
    input  logic [WIDTH_OUT_DATA:0] SHIFT_IN,
    input  logic                    SHIFT_Valid,
    output logic                    Ser_Out,
    output logic                    Ser_Busy,
    output logic                    Ser_Full,
    output logic                    Ser_Done,
    output logic                    Ser_Overrun
);

    // state  | meaning
    // IDLE   | line high, waiting for a word
    // START  | start bit (0)
    // DATA   | data bits, LSB first
    // PARITY | even parity bit (only with SHIFT_SER_PARITY_EN)
    // STOP   | stop bit (1); last tick may chain straight into START

    localparam int DW = WIDTH_OUT_DATA + 1;
    localparam int TW = (BIT_TICKS > 1) ? $clog2(BIT_TICKS) : 1;
    localparam int BW = $clog2(DW);

    localparam logic [TW-1:0] TICK_LAST = TW'(BIT_TICKS - 1);
    localparam logic [BW-1:0] BIT_LAST  = BW'(WIDTH_OUT_DATA);

    localparam logic [2:0] S_IDLE   = 3'd0;
    localparam logic [2:0] S_START  = 3'd1;
    localparam logic [2:0] S_DATA   = 3'd2;
`ifdef SHIFT_SER_PARITY_EN
    localparam logic [2:0] S_PARITY = 3'd3;
`endif
    localparam logic [2:0] S_STOP   = 3'd4;

    logic [2:0]    r_state;
    logic [TW-1:0] r_tick;
    logic [BW-1:0] r_bit;
    logic [DW-1:0] r_shift;
    logic [DW-1:0] r_buf;
    logic          r_full;
    logic          r_overrun;
    logic          r_ser_out;

    logic [2:0]    w_state_nxt;
    logic [TW-1:0] w_tick_nxt;
    logic [BW-1:0] w_bit_nxt;
    logic [DW-1:0] w_shift_nxt;
    logic [DW-1:0] w_buf_nxt;
    logic          w_full_nxt;
    logic          w_overrun_nxt;
    logic          w_out_nxt;
    logic          w_load;
    logic [DW-1:0] w_load_data;
    logic          w_last_tick;
    logic          w_stop_end;

`ifdef SHIFT_SER_PARITY_EN
    logic          r_parity;
`endif

    assign w_last_tick = (r_tick == TICK_LAST);
    assign w_stop_end  = (r_state == S_STOP) && w_last_tick;

    always_comb begin
        w_state_nxt   = r_state;
        w_tick_nxt    = w_last_tick ? '0 : r_tick + TW'(1);
        w_bit_nxt     = r_bit;
        w_shift_nxt   = r_shift;
        w_buf_nxt     = r_buf;
        w_full_nxt    = r_full;
        w_overrun_nxt = r_overrun;
        w_load        = 1'b0;
        w_load_data   = SHIFT_IN;

        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                if (SHIFT_Valid) begin
                    w_load      = 1'b1;
                    w_state_nxt = S_START;
                end
            end
            S_START: begin
                if (w_last_tick) begin
                    w_state_nxt = S_DATA;
                    w_bit_nxt   = '0;
                end
            end
            S_DATA: begin
                if (w_last_tick) begin
                    w_shift_nxt = r_shift >> 1;
                    if (r_bit == BIT_LAST) begin
                        w_bit_nxt   = '0;
`ifdef SHIFT_SER_PARITY_EN
                        w_state_nxt = S_PARITY;
`else
                        w_state_nxt = S_STOP;
`endif
                    end else begin
                        w_bit_nxt = r_bit + BW'(1);
                    end
                end
            end
`ifdef SHIFT_SER_PARITY_EN
            S_PARITY: begin
                if (w_last_tick) begin
                    w_state_nxt = S_STOP;
                end
            end
`endif
            S_STOP: begin
                if (w_last_tick) begin
                    if (r_full) begin
                        // buffered word goes out first; a same-cycle Valid refills the freed slot
                        w_load      = 1'b1;
                        w_load_data = r_buf;
                        w_state_nxt = S_START;
                        if (SHIFT_Valid) begin
                            w_buf_nxt = SHIFT_IN;
                        end else begin
                            w_full_nxt = 1'b0;
                        end
                    end else if (SHIFT_Valid) begin
                        w_load      = 1'b1;
                        w_state_nxt = S_START;
                    end else begin
                        w_state_nxt = S_IDLE;
                    end
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
            end
        endcase

        if ((r_state != S_IDLE) && SHIFT_Valid && !w_stop_end) begin
            if (!r_full) begin
                w_buf_nxt  = SHIFT_IN;
                w_full_nxt = 1'b1;
            end else begin
                w_overrun_nxt = 1'b1;
            end
        end

        if (w_load) begin
            w_shift_nxt = w_load_data;
        end

        case (w_state_nxt)
            S_START: w_out_nxt = 1'b0;
            S_DATA:  w_out_nxt = w_shift_nxt[0];
`ifdef SHIFT_SER_PARITY_EN
            S_PARITY: w_out_nxt = r_parity;
`endif
            default: w_out_nxt = 1'b1;
        endcase
    end

    always_ff @(posedge CLK_shift or negedge RST_shift) begin
        if (!RST_shift) begin
            r_state   <= S_IDLE;
            r_tick    <= '0;
            r_bit     <= '0;
            r_shift   <= '0;
            r_buf     <= '0;
            r_full    <= 1'b0;
            r_overrun <= 1'b0;
            r_ser_out <= 1'b1;
        end else begin
            r_state   <= w_state_nxt;
            r_tick    <= w_tick_nxt;
            r_bit     <= w_bit_nxt;
            r_shift   <= w_shift_nxt;
            r_buf     <= w_buf_nxt;
            r_full    <= w_full_nxt;
            r_overrun <= w_overrun_nxt;
            r_ser_out <= w_out_nxt;
        end
    end

`ifdef SHIFT_SER_PARITY_EN
    // parity is taken from the whole word as it is loaded, so shifting does not disturb it
    always_ff @(posedge CLK_shift or negedge RST_shift) begin
        if (!RST_shift) begin
            r_parity <= 1'b0;
        end else if (w_load) begin
            r_parity <= ^w_load_data;
        end
    end
`endif

    assign Ser_Out     = r_ser_out;
    assign Ser_Busy    = (r_state != S_IDLE);
    assign Ser_Full    = r_full;
    assign Ser_Done    = w_stop_end;
    assign Ser_Overrun = r_overrun;

endmodule

// File: tb/tb_shift_serializer.sv
// Scoreboard bench for shift_serializer: accepted words are queued and compared bit-by-bit on the line.
// Define SHIFT_SER_PARITY_EN for both bench and RTL to cover the parity build.
module tb_shift_serializer;

    localparam int W  = 16;
    localparam int BT = 4;
    localparam int DW = W + 1;
`ifdef SHIFT_SER_PARITY_EN
    localparam int FL = (W + 4) * BT;
`else
    localparam int FL = (W + 3) * BT;
`endif

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [DW-1:0] din = '0;
    logic          vld = 1'b0;
    logic          ser_out, busy, full, done, ovr;

    shift_serializer #(.WIDTH_OUT_DATA(W), .BIT_TICKS(BT)) dut (
        .CLK_shift  (clk),
        .RST_shift  (rst_n),
        .SHIFT_IN   (din),
        .SHIFT_Valid(vld),
        .Ser_Out    (ser_out),
        .Ser_Busy   (busy),
        .Ser_Full   (full),
        .Ser_Done   (done),
        .Ser_Overrun(ovr)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;
    int cyc = 0;
    logic [DW-1:0] exp_q[$];

    logic          in_frame = 1'b0;
    int            pos = 0;
    logic [DW-1:0] cur = '0;
    int            start_cyc = -1;
    int            done_cyc = -1;
    int            frames = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (cyc %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic logic exp_level(input logic [DW-1:0] w, input int p);
        int slot;
        slot = p / BT;
        if (slot == 0) return 1'b0;
        if (slot <= DW) return w[slot-1];
`ifdef SHIFT_SER_PARITY_EN
        if (slot == DW + 1) return ^w;
`endif
        return 1'b1;
    endfunction

    initial forever begin
        @(posedge clk);
        cyc++;
    end

    // line monitor: frames start when Busy rises and are checked cycle by cycle
    initial forever begin
        @(negedge clk);
        if (!rst_n) begin
            in_frame = 1'b0;
        end else begin
            if (!in_frame && busy) begin
                in_frame  = 1'b1;
                pos       = 0;
                start_cyc = cyc;
                chk("sb_pending", (exp_q.size() != 0), 1);
                cur = (exp_q.size() != 0) ? exp_q.pop_front() : '0;
            end
            if (in_frame) begin
                chk("ser_out", ser_out, exp_level(cur, pos));
                chk("done", done, (pos == FL - 1));
                chk("busy", busy, 1);
                if (pos == FL - 1) begin
                    done_cyc = cyc;
                    frames++;
                    in_frame = 1'b0;
                end else begin
                    pos++;
                end
            end else begin
                chk("out_idle", ser_out, 1);
            end
        end
    end

    task automatic nclk(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic pulse(input logic [DW-1:0] d);
        #1;
        din = d;
        vld = 1'b1;
        @(posedge clk);
        #1;
        vld = 1'b0;
        din = '0;
    endtask

    task automatic wait_done(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (done) break;
        end
        chk("done_seen", done, 1);
    endtask

    task automatic wait_idle(input int budget);
        for (int i = 0; i < budget; i++) begin
            @(negedge clk);
            if (!busy) break;
        end
        chk("idle_reached", busy, 0);
    endtask

    int acc;
    int d_cyc;
    int f0;
    int guard;

    initial begin
        nclk(3);
        chk("rst_out", ser_out, 1);
        chk("rst_busy", busy, 0);
        chk("rst_full", full, 0);
        chk("rst_done", done, 0);
        chk("rst_ovr", ovr, 0);

        // release and accept on the very first edge
        @(negedge clk);
        #1 rst_n = 1'b1;
        exp_q.push_back(17'h0_00A5);
        pulse(17'h0_00A5);
        acc = cyc;
        @(negedge clk);
        #1;
        chk("latency", start_cyc, acc);
        chk("idle_no_buf", full, 0);
        wait_done(FL + 10);
        #1;
        chk("done_cyc", done_cyc - acc, FL - 1);
        @(negedge clk);
        #1;
        chk("busy_after", busy, 0);

        exp_q.push_back(17'h1_0003);
        pulse(17'h1_0003);
        wait_idle(FL + 10);
        chk("q_empty1", exp_q.size(), 0);

        // back-to-back through the buffer
        @(negedge clk);
        exp_q.push_back(17'h0_0001);
        pulse(17'h0_0001);
        nclk(20);
        exp_q.push_back(17'h1_FFFF);
        pulse(17'h1_FFFF);
        chk("b2b_full", full, 1);
        wait_done(FL + 10);
        chk("b2b_full_stop", full, 1);
        #1 d_cyc = done_cyc;
        @(negedge clk);
        #1;
        chk("b2b_gap", start_cyc, d_cyc + 1);
        chk("b2b_full_clr", full, 0);
        wait_idle(2 * FL + 10);
        chk("q_empty2", exp_q.size(), 0);

        // Valid on the final STOP cycle with the buffer full
        f0 = frames;
        @(negedge clk);
        exp_q.push_back(17'h0_1234);
        pulse(17'h0_1234);
        nclk(10);
        exp_q.push_back(17'h1_5A5A);
        pulse(17'h1_5A5A);
        wait_done(FL + 10);
        exp_q.push_back(17'h0_0F0F);
        pulse(17'h0_0F0F);
        chk("eof_full", full, 1);
        chk("eof_ovr", ovr, 0);
        wait_idle(3 * FL + 10);
        chk("eof_frames", frames - f0, 3);
        chk("eof_ovr_end", ovr, 0);
        chk("q_empty3", exp_q.size(), 0);

        // overrun: third word dropped, flag sticky
        f0 = frames;
        @(negedge clk);
        exp_q.push_back(17'h0_00C3);
        pulse(17'h0_00C3);
        nclk(8);
        exp_q.push_back(17'h1_8001);
        pulse(17'h1_8001);
        nclk(8);
        pulse(17'h0_7777);
        chk("ovr_set", ovr, 1);
        chk("ovr_full", full, 1);
        wait_idle(3 * FL + 10);
        chk("ovr_frames", frames - f0, 2);
        chk("q_empty4", exp_q.size(), 0);
        @(negedge clk);
        exp_q.push_back(17'h0_0055);
        pulse(17'h0_0055);
        wait_idle(FL + 10);
        chk("ovr_sticky", ovr, 1);

        // reset during DATA bit 5 with a word buffered
        @(negedge clk);
        exp_q.push_back(17'h1_2345);
        pulse(17'h1_2345);
        acc = cyc;
        nclk(3);
        exp_q.push_back(17'h0_6789);
        pulse(17'h0_6789);
        guard = 0;
        while (cyc < acc + 6 * BT + 1 && guard < 1000) begin
            @(posedge clk);
            guard++;
        end
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_out", ser_out, 1);
        chk("mid_rst_busy", busy, 0);
        chk("mid_rst_full", full, 0);
        chk("mid_rst_ovr", ovr, 0);
        exp_q.delete();
        nclk(2);
        @(posedge clk);
        #2 rst_n = 1'b1;
        exp_q.push_back(17'h0_4321);
        pulse(17'h0_4321);
        chk("post_rst_busy", busy, 1);
        wait_idle(FL + 10);
        chk("q_empty5", exp_q.size(), 0);

        nclk(2);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
